// File: rtl/blackparrot_fpga_host_write_arbiter_pkg.sv
// Shared types for the host AXI-Lite write arbiter.
package blackparrot_fpga_host_write_arbiter_pkg;
  typedef enum logic [1:0] {
    e_idle,
    e_send,
    e_resp
  } wr_state_e;

  function automatic int lg(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bsg_axi_pkg.sv
// AXI response codes shared by the host AXI-Lite blocks.
package bsg_axi_pkg;
  typedef enum logic [1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_exokay = 2'b01,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } axi_resp_e;
endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter; pointer moves past the winner on yumi_i.
module bsg_arb_round_robin
  import blackparrot_fpga_host_write_arbiter_pkg::*;
#(
  parameter int width_p = 2,
  localparam int LG_P = lg(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] reqs_i,
  output logic [width_p-1:0] grants_o,
  output logic [LG_P-1:0]    grant_id_o,
  input  logic               yumi_i
);
  logic [LG_P-1:0] r_ptr;
  logic            w_found;
  int unsigned     w_j;

  always_comb begin
    grants_o   = '0;
    grant_id_o = '0;
    w_found    = 1'b0;
    w_j        = 0;
    for (int k = 0; k < width_p; k++) begin
      w_j = (int'(r_ptr) + k) % width_p;
      if (!w_found && reqs_i[w_j]) begin
        w_found    = 1'b1;
        grant_id_o = LG_P'(w_j);
      end
    end
    if (w_found) grants_o[grant_id_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (yumi_i) begin
      if (grant_id_o == LG_P'(width_p - 1)) r_ptr <= '0;
      else r_ptr <= grant_id_o + 1'b1;
    end
  end
endmodule

// File: rtl/blackparrot_fpga_host_write_arbiter.sv
// Round-robin share of one AXI-Lite write master among
// fixed-address requesters, one outstanding write at a time.
module blackparrot_fpga_host_write_arbiter
  import bsg_axi_pkg::*;
  import blackparrot_fpga_host_write_arbiter_pkg::*;
#(
  parameter int M_AXIL_ADDR_WIDTH = 64,
  parameter int M_AXIL_DATA_WIDTH = 32,
  parameter int REQ_ELS_P = 2,
  parameter logic [M_AXIL_ADDR_WIDTH-1:0]
    req_addr_p [REQ_ELS_P] = '{default: '0},
  localparam int LG_P = lg(REQ_ELS_P),
  localparam int DW = M_AXIL_DATA_WIDTH
) (
  input  logic                         m_axil_aclk,
  input  logic                         m_axil_areset,
  input  logic [REQ_ELS_P-1:0]         req_v_i,
  input  logic [REQ_ELS_P*DW-1:0]      req_data_i,
  output logic [REQ_ELS_P-1:0]         req_yumi_o,
  output logic [M_AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]                   m_axil_awprot,
  output logic                         m_axil_awvalid,
  input  logic                         m_axil_awready,
  output logic [DW-1:0]                m_axil_wdata,
  output logic [DW/8-1:0]              m_axil_wstrb,
  output logic                         m_axil_wvalid,
  input  logic                         m_axil_wready,
  input  logic                         m_axil_bvalid,
  input  logic [1:0]                   m_axil_bresp,
  output logic                         m_axil_bready,
  output logic                         busy_o,
  output logic                         err_o,
  output logic [LG_P-1:0]              err_id_o,
  input  logic                         err_clear_i
);
  wr_state_e r_state, w_state_n;
  logic      r_aw_done, r_w_done;
  logic [M_AXIL_ADDR_WIDTH-1:0] r_addr;
  logic [DW-1:0]   r_data;
  logic [LG_P-1:0] r_id;
  logic            r_err;
  logic [LG_P-1:0] r_err_id;

  logic [REQ_ELS_P-1:0] w_grants;
  logic [LG_P-1:0]      w_grant_id;
  logic w_accept, w_aw_fin, w_w_fin;
  logic w_b_hs, w_b_fail;

  bsg_arb_round_robin #(
    .width_p(REQ_ELS_P)
  ) u_arb (
    .clk_i     (m_axil_aclk),
    .reset_i   (m_axil_areset),
    .reqs_i    (req_v_i),
    .grants_o  (w_grants),
    .grant_id_o(w_grant_id),
    .yumi_i    (w_accept)
  );

  // Reset gating keeps yumi low while held in reset in e_idle.
  assign w_accept = (r_state == e_idle) & (|req_v_i)
                  & ~m_axil_areset;
  assign req_yumi_o = w_accept ? w_grants : '0;

  assign m_axil_awaddr  = r_addr;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = (r_state == e_send) & ~r_aw_done;
  assign m_axil_wdata   = r_data;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = (r_state == e_send) & ~r_w_done;
  assign m_axil_bready  = (r_state == e_resp);

  assign busy_o   = (r_state != e_idle);
  assign err_o    = r_err;
  assign err_id_o = r_err_id;

  assign w_aw_fin = r_aw_done | (m_axil_awvalid & m_axil_awready);
  assign w_w_fin  = r_w_done | (m_axil_wvalid & m_axil_wready);
  assign w_b_hs   = (r_state == e_resp) & m_axil_bvalid;
  assign w_b_fail = w_b_hs & (m_axil_bresp != e_axi_resp_okay)
                  & (~r_err | err_clear_i);

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      e_idle: if (w_accept) w_state_n = e_send;
      e_send: if (w_aw_fin & w_w_fin) w_state_n = e_resp;
      e_resp: if (m_axil_bvalid) w_state_n = e_idle;
      default: w_state_n = e_idle;
    endcase
  end

  always_ff @(posedge m_axil_aclk or posedge m_axil_areset) begin
    if (m_axil_areset) begin
      r_state   <= e_idle;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_id      <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_accept) begin
        r_addr <= req_addr_p[w_grant_id];
        r_data <= req_data_i[w_grant_id*DW +: DW];
        r_id   <= w_grant_id;
      end
      if ((r_state == e_send) & ~(w_aw_fin & w_w_fin)) begin
        r_aw_done <= w_aw_fin;
        r_w_done  <= w_w_fin;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge m_axil_aclk or posedge m_axil_areset) begin
    if (m_axil_areset) begin
      r_err    <= 1'b0;
      r_err_id <= '0;
    end else if (w_b_fail) begin
      r_err    <= 1'b1;
      r_err_id <= r_id;
    end else if (err_clear_i) begin
      r_err    <= 1'b0;
      r_err_id <= '0;
    end
  end
endmodule

// File: tb/tb_blackparrot_fpga_host_write_arbiter.sv
// Bench: queue-based requesters, AXI-Lite slave and
// transaction-level model of the write arbiter.
module tb_blackparrot_fpga_host_write_arbiter;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam logic [AW-1:0] ADDRS [N] =
    '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_2008};

  logic clk, rst;
  logic [N-1:0] req_v, yumi;
  logic [N*DW-1:0] req_data;
  logic [AW-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic busy, err, err_clear;
  logic [0:0] err_id;

  blackparrot_fpga_host_write_arbiter #(
    .M_AXIL_ADDR_WIDTH(AW),
    .M_AXIL_DATA_WIDTH(DW),
    .REQ_ELS_P(N),
    .req_addr_p(ADDRS)
  ) dut (
    .m_axil_aclk   (clk),
    .m_axil_areset (rst),
    .req_v_i       (req_v),
    .req_data_i    (req_data),
    .req_yumi_o    (yumi),
    .m_axil_awaddr (awaddr),
    .m_axil_awprot (awprot),
    .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata  (wdata),
    .m_axil_wstrb  (wstrb),
    .m_axil_wvalid (wvalid),
    .m_axil_wready (wready),
    .m_axil_bvalid (bvalid),
    .m_axil_bresp  (bresp),
    .m_axil_bready (bready),
    .busy_o        (busy),
    .err_o         (err),
    .err_id_o      (err_id),
    .err_clear_i   (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int id;
  } txn_t;

  // requester word queues
  logic [DW-1:0] rq0[$];
  logic [DW-1:0] rq1[$];

  // model state
  txn_t expq[$];
  int   m_next;
  bit   m_inflight, m_aw, m_w, m_err;
  int   m_err_id;

  // slave config/state
  int aw_dly = 0, w_dly = 0;
  int aw_cnt, w_cnt;
  bit s_aw, s_w, s_pend;
  logic [1:0] bresp_cfg = 2'b00;

  // per-test statistics
  int n_yumi, n_aw, n_w, n_b, awv_cyc, wv_cyc, yumi_cyc;
  int glog[$];
  logic [AW-1:0] last_awaddr;
  logic [DW-1:0] last_wdata;
  logic [DW/8-1:0] last_wstrb;

  function automatic int pick(input logic [N-1:0] v, input int nx);
    for (int i = 0; i < N; i++)
      if (v[(nx + i) % N]) return (nx + i) % N;
    return -1;
  endfunction

  task automatic clr_stats();
    n_yumi = 0; n_aw = 0; n_w = 0; n_b = 0;
    awv_cyc = 0; wv_cyc = 0; yumi_cyc = -1;
    glog.delete();
    last_awaddr = '0; last_wdata = '0; last_wstrb = '0;
  endtask

  always @(negedge clk) begin
    logic [N-1:0] exp_yumi;
    int g;
    bit aw_hs, w_hs, b_hs;
    txn_t t;
    if (rst) begin
      expq.delete();
      m_next = 0; m_inflight = 0; m_aw = 0; m_w = 0;
      m_err = 0; m_err_id = 0;
      aw_cnt = 0; w_cnt = 0; s_aw = 0; s_w = 0; s_pend = 0;
      req_v = '0; req_data = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    end else begin
      req_v[0] = (rq0.size() > 0);
      req_v[1] = (rq1.size() > 0);
      req_data[DW-1:0]    = req_v[0] ? rq0[0] : '0;
      req_data[2*DW-1:DW] = req_v[1] ? rq1[0] : '0;
      awready = awvalid && (aw_cnt >= aw_dly);
      wready  = wvalid && (w_cnt >= w_dly);
      bvalid  = s_pend;
      bresp   = s_pend ? bresp_cfg : 2'b00;
      #1;
      exp_yumi = '0;
      g = -1;
      if (!m_inflight && req_v != '0) begin
        g = pick(req_v, m_next);
        exp_yumi[g] = 1'b1;
      end
      chk("yumi", yumi, exp_yumi);
      chk("busy", busy, m_inflight);
      chk("awvalid", awvalid, m_inflight && !m_aw);
      chk("wvalid", wvalid, m_inflight && !m_w);
      chk("bready", bready, m_inflight && m_aw && m_w);
      chk("awprot", awprot, 3'b000);
      chk("wstrb", wstrb, 4'hF);
      chk("err", err, m_err);
      chk("err_id", err_id, m_err_id);
      if (awvalid && expq.size() > 0)
        chk("awaddr", awaddr, expq[0].addr);
      if (wvalid && expq.size() > 0)
        chk("wdata", wdata, expq[0].data);

      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (awvalid) awv_cyc++;
      if (wvalid) wv_cyc++;
      if (aw_hs) begin
        n_aw++; last_awaddr = awaddr;
        m_aw = 1; s_aw = 1; aw_cnt = 0;
      end else if (awvalid) aw_cnt++;
      if (w_hs) begin
        n_w++; last_wdata = wdata; last_wstrb = wstrb;
        m_w = 1; s_w = 1; w_cnt = 0;
      end else if (wvalid) w_cnt++;
      if (s_aw && s_w) begin
        s_pend = 1; s_aw = 0; s_w = 0;
      end
      if (b_hs) begin
        n_b++; s_pend = 0;
        m_inflight = 0; m_aw = 0; m_w = 0;
        if (bresp != 2'b00 && (!m_err || err_clear)) begin
          m_err = 1;
          m_err_id = (expq.size() > 0) ? expq[0].id : 0;
        end else if (err_clear) begin
          m_err = 0; m_err_id = 0;
        end
        if (expq.size() > 0) void'(expq.pop_front());
      end else if (err_clear) begin
        m_err = 0; m_err_id = 0;
      end
      if (yumi[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (yumi[1] && rq1.size() > 0) void'(rq1.pop_front());
      if (yumi != '0) begin
        n_yumi++;
        if (yumi_cyc < 0) yumi_cyc = cyc;
      end
      if (g >= 0) begin
        t.addr = ADDRS[g];
        t.data = req_data[g*DW +: DW];
        t.id = g;
        expq.push_back(t);
        m_inflight = 1;
        m_next = (g + 1) % N;
        glog.push_back(g);
      end
    end
  end

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while ((rq0.size() != 0 || rq1.size() != 0 ||
            m_inflight || busy) && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    @(posedge clk); #2;
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s timeout actual=%0d required<%0d",
               nm, k, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int rel_cyc;
    int k;
    int exp2 [6] = '{0, 1, 0, 1, 0, 1};
    rst = 1; err_clear = 0;
    req_v = '0; req_data = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    clr_stats();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_id", err_id, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_yumi", yumi, 2'b00);

    // 1: single word from requester 0
    rq0.push_back(32'hDEADBEEF);
    @(posedge clk); #2;
    rst = 0;
    rel_cyc = cyc;
    wait_idle(50, "t1");
    chk("t1_yumi_cycle", yumi_cyc - rel_cyc, 0);
    chk("t1_grant", glog.size() > 0 ? glog[0] : 99, 0);
    chk("t1_awaddr", last_awaddr, 64'h1000);
    chk("t1_wdata", last_wdata, 32'hDEADBEEF);
    chk("t1_wstrb", last_wstrb, 4'hF);
    chk("t1_nb", n_b, 1);
    chk("t1_busy_end", busy, 1'b0);

    // 2: both requesters continuously valid
    do_reset();
    clr_stats();
    for (int i = 0; i < 3; i++) begin
      rq0.push_back(32'h1000_0000 + i);
      rq1.push_back(32'h2000_0000 + i);
    end
    wait_idle(100, "t2");
    chk("t2_nyumi", n_yumi, 6);
    chk("t2_glog_len", glog.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("t2_order", i < glog.size() ? glog[i] : 99, exp2[i]);

    // 3: awready delayed
    clr_stats();
    aw_dly = 3; w_dly = 0;
    rq1.push_back(32'h1234_5678);
    wait_idle(50, "t3");
    chk("t3_naw", n_aw, 1);
    chk("t3_nw", n_w, 1);
    chk("t3_awv_cycles", awv_cyc, 4);
    chk("t3_awaddr", last_awaddr, 64'h2008);
    chk("t3_wdata", last_wdata, 32'h1234_5678);

    // 4: wready delayed
    clr_stats();
    aw_dly = 0; w_dly = 3;
    rq0.push_back(32'hA5A5_0001);
    wait_idle(50, "t4");
    chk("t4_naw", n_aw, 1);
    chk("t4_nw", n_w, 1);
    chk("t4_nyumi", n_yumi, 1);
    chk("t4_nb", n_b, 1);
    chk("t4_wv_cycles", wv_cyc, 4);
    chk("t4_wdata", last_wdata, 32'hA5A5_0001);
    w_dly = 0;

    // 5: slave errors and clear
    bresp_cfg = 2'b10;
    rq1.push_back(32'h0000_0011);
    wait_idle(50, "t5a");
    chk("t5_err_set", err, 1'b1);
    chk("t5_err_id", err_id, 1'b1);
    rq0.push_back(32'h0000_0022);
    wait_idle(50, "t5b");
    chk("t5_err_sticky", err, 1'b1);
    chk("t5_err_id_first", err_id, 1'b1);
    bresp_cfg = 2'b00;
    err_clear = 1;
    @(posedge clk); #2;
    err_clear = 0;
    chk("t5_err_clear", err, 1'b0);

    // 6: reset during e_send
    aw_dly = 5;
    rq1.push_back(32'h0000_0033);
    k = 0;
    while (!busy && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    chk("t6_busy_seen", busy, 1'b1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("t6_awvalid", awvalid, 1'b0);
    chk("t6_wvalid", wvalid, 1'b0);
    chk("t6_bready", bready, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_yumi", yumi, 2'b00);
    aw_dly = 0;
    clr_stats();
    rq0.push_back(32'h0000_0044);
    rq1.push_back(32'h0000_0055);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    wait_idle(50, "t6");
    chk("t6_first_grant", glog.size() > 0 ? glog[0] : 99, 0);
    chk("t6_nyumi", n_yumi, 2);
    chk("t6_nb", n_b, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
